// File: rtl/logic_op_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// logic_op_arbiter_pkg : shared widths and rotate-priority helper
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package logic_op_arbiter_pkg;

  localparam int ADDRS_WIDTH_DEF = 4;
  localparam int DATA_WIDTH_DEF  = 64;
  localparam int NREQ_MAX        = 8;
  localparam int PTR_W           = $clog2(NREQ_MAX);

  typedef logic [NREQ_MAX-1:0] req_vec_t;
  typedef logic [PTR_W-1:0]    ptr_t;

  // First set bit of elig at or after ptr, wrapping modulo n.
  function automatic req_vec_t rotate_priority(input req_vec_t elig,
                                               input ptr_t     ptr,
                                               input int       n);
    req_vec_t gnt;
    logic     found;
    int       idx;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ_MAX; k++) begin
      idx = (int'(ptr) + k) % n;
      if ((k < n) && !found && elig[ptr_t'(idx)]) begin
        gnt[ptr_t'(idx)] = 1'b1;
        found            = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/logic_op_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// logic_op_arbiter_rr_pick : combinational round-robin picker, one-hot + index
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module logic_op_arbiter_rr_pick
  import logic_op_arbiter_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] elig_i,
  input  ptr_t            ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output ptr_t            idx_o
);

  req_vec_t elig_ext;
  req_vec_t gnt_ext;

  always_comb begin
    elig_ext             = '0;
    elig_ext[NREQ-1:0]   = elig_i;
  end

  assign gnt_ext = rotate_priority(elig_ext, ptr_i, NREQ);
  assign gnt_o   = gnt_ext[NREQ-1:0];

  always_comb begin
    idx_o = '0;
    for (int i = 0; i < NREQ_MAX; i++) begin
      if (gnt_ext[i]) idx_o = ptr_t'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/logic_op_arbiter.sv
// ----------------------------------------------------------------------------
// logic_op_arbiter : round-robin issue arbiter and result-slot scoreboard
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module logic_op_arbiter
  import logic_op_arbiter_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int ADDRS_WIDTH = ADDRS_WIDTH_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ*ADDRS_WIDTH-1:0] req_addrs,
  input  logic [NREQ*DATA_WIDTH-1:0]  req_oprndA,
  input  logic [NREQ*DATA_WIDTH-1:0]  req_oprndB,
  output logic [NREQ-1:0]             gnt,
  input  logic                        op_ready,
  output logic                        wren,
  output logic [ADDRS_WIDTH-1:0]      wraddrs,
  output logic [DATA_WIDTH-1:0]       oprndA,
  output logic [DATA_WIDTH-1:0]       oprndB,
  input  logic                        rel,
  input  logic [ADDRS_WIDTH-1:0]      rel_addrs,
  output logic [2**ADDRS_WIDTH-1:0]   slot_valid,
  output logic [15:0]                 issued_cnt
);

  localparam int NSLOT = 2**ADDRS_WIDTH;

  logic [NREQ-1:0]        elig;
  logic [NREQ-1:0]        pick_gnt;
  ptr_t                   pick_idx;
  logic                   any_gnt;

  ptr_t                   rr_ptr_q, rr_ptr_d;
  logic                   wren_q, wren_d;
  logic [ADDRS_WIDTH-1:0] wraddrs_q, wraddrs_d;
  logic [DATA_WIDTH-1:0]  oprndA_q, oprndA_d;
  logic [DATA_WIDTH-1:0]  oprndB_q, oprndB_d;
  logic [NSLOT-1:0]       slot_valid_q, slot_valid_d;
  logic [15:0]            cnt_q, cnt_d;

  logic [ADDRS_WIDTH-1:0] sel_addrs;
  logic [DATA_WIDTH-1:0]  sel_a;
  logic [DATA_WIDTH-1:0]  sel_b;

  // The in-flight write is not yet visible in slot_valid, so it is matched directly.
  generate
    for (genvar i = 0; i < NREQ; i++) begin : g_elig
      logic [ADDRS_WIDTH-1:0] addr;
      assign addr    = req_addrs[i*ADDRS_WIDTH +: ADDRS_WIDTH];
      assign elig[i] = req[i] && !slot_valid_q[addr] && !(wren_q && (addr == wraddrs_q));
    end
  endgenerate

  logic_op_arbiter_rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .elig_i (elig),
    .ptr_i  (rr_ptr_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx)
  );

  assign gnt     = (op_ready && !RESET) ? pick_gnt : '0;
  assign any_gnt = |gnt;

  always_comb begin
    sel_addrs = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_addrs = req_addrs[i*ADDRS_WIDTH +: ADDRS_WIDTH];
        sel_a     = req_oprndA[i*DATA_WIDTH +: DATA_WIDTH];
        sel_b     = req_oprndB[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    wren_d    = any_gnt;
    wraddrs_d = wraddrs_q;
    oprndA_d  = oprndA_q;
    oprndB_d  = oprndB_q;
    if (any_gnt) begin
      rr_ptr_d  = (int'(pick_idx) == NREQ-1) ? '0 : pick_idx + 1'b1;
      wraddrs_d = sel_addrs;
      oprndA_d  = sel_a;
      oprndB_d  = sel_b;
    end
  end

  // Set is applied after clear so a same-edge write to a released slot survives.
  always_comb begin
    slot_valid_d = slot_valid_q;
    if (rel)    slot_valid_d[rel_addrs] = 1'b0;
    if (wren_q) slot_valid_d[wraddrs_q] = 1'b1;
    cnt_d = wren_q ? cnt_q + 16'd1 : cnt_q;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rr_ptr_q     <= '0;
      wren_q       <= 1'b0;
      wraddrs_q    <= '0;
      oprndA_q     <= '0;
      oprndB_q     <= '0;
      slot_valid_q <= '0;
      cnt_q        <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      wren_q       <= wren_d;
      wraddrs_q    <= wraddrs_d;
      oprndA_q     <= oprndA_d;
      oprndB_q     <= oprndB_d;
      slot_valid_q <= slot_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign wren       = wren_q;
  assign wraddrs    = wraddrs_q;
  assign oprndA     = oprndA_q;
  assign oprndB     = oprndB_q;
  assign slot_valid = slot_valid_q;
  assign issued_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_logic_op_arbiter.sv
// ----------------------------------------------------------------------------
// tb_logic_op_arbiter : directed self-checking bench for logic_op_arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_logic_op_arbiter;

  logic          CLK;
  logic          RESET;
  logic [3:0]    req;
  logic [15:0]   req_addrs;
  logic [255:0]  req_oprndA;
  logic [255:0]  req_oprndB;
  logic [3:0]    gnt;
  logic          op_ready;
  logic          wren;
  logic [3:0]    wraddrs;
  logic [63:0]   oprndA;
  logic [63:0]   oprndB;
  logic          rel;
  logic [3:0]    rel_addrs;
  logic [15:0]   slot_valid;
  logic [15:0]   issued_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  logic_op_arbiter #(
    .NREQ        (4),
    .ADDRS_WIDTH (4),
    .DATA_WIDTH  (64)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .req        (req),
    .req_addrs  (req_addrs),
    .req_oprndA (req_oprndA),
    .req_oprndB (req_oprndB),
    .gnt        (gnt),
    .op_ready   (op_ready),
    .wren       (wren),
    .wraddrs    (wraddrs),
    .oprndA     (oprndA),
    .oprndB     (oprndB),
    .rel        (rel),
    .rel_addrs  (rel_addrs),
    .slot_valid (slot_valid),
    .issued_cnt (issued_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Called mid-cycle; releases well before the next rising edge.
  task automatic pulse_reset();
    RESET = 1'b1;
    #1;
    RESET = 1'b0;
  endtask

  initial begin
    RESET     = 1'b1;
    op_ready  = 1'b1;
    req       = 4'b1111;
    req_addrs = 16'h3210;
    rel       = 1'b0;
    rel_addrs = 4'd0;
    for (int i = 0; i < 4; i++) begin
      req_oprndA[i*64 +: 64] = 64'h1111_0000_0000_0000 + 64'(i);
      req_oprndB[i*64 +: 64] = 64'h2222_0000_0000_0000 + 64'(i);
    end

    // Reset state with every requester asking
    repeat (2) @(posedge CLK);
    #1; #4;
    check("rst_gnt",   64'(gnt), 64'h0);
    check("rst_wren",  64'(wren), 64'h0);
    check("rst_slots", 64'(slot_valid), 64'h0);
    check("rst_cnt",   64'(issued_cnt), 64'h0);
    req   = 4'b0000;
    RESET = 1'b0;
    tick();

    // Rotation over slots 0..3, releasing each slot once it lands
    req = 4'b1111; req_addrs = 16'h3210;
    #4; check("rot_gnt1", 64'(gnt), 64'h1);
    tick();
    #4; check("rot_gnt2", 64'(gnt), 64'h2);
    check("rot_wren2", 64'(wren), 64'h1);
    check("rot_wa2",   64'(wraddrs), 64'h0);
    check("rot_opA2",  oprndA, 64'h1111_0000_0000_0000);
    tick();
    rel = 1'b1; rel_addrs = 4'd0;
    #4; check("rot_gnt3", 64'(gnt), 64'h4);
    check("rot_wren3", 64'(wren), 64'h1);
    check("rot_wa3",   64'(wraddrs), 64'h1);
    check("rot_opB3",  oprndB, 64'h2222_0000_0000_0001);
    tick();
    rel_addrs = 4'd1;
    #4; check("rot_gnt4", 64'(gnt), 64'h8);
    check("rot_wren4", 64'(wren), 64'h1);
    tick();
    rel_addrs = 4'd2;
    #4; check("rot_gnt5", 64'(gnt), 64'h1);
    check("rot_wren5", 64'(wren), 64'h1);
    tick();
    req = 4'b0000; rel = 1'b0;
    #4;
    // Asynchronous reset while a write is in flight
    RESET = 1'b1;
    #1;
    check("arst_wren",  64'(wren), 64'h0);
    check("arst_slots", 64'(slot_valid), 64'h0);
    check("arst_gnt",   64'(gnt), 64'h0);
    RESET = 1'b0;
    tick();

    // Occupancy blocking on slot 5
    req = 4'b0001; req_addrs = 16'h0005;
    #4; check("occ_gntA", 64'(gnt), 64'h1);
    tick();
    #4; check("occ_hazB", 64'(gnt), 64'h0);
    check("occ_waB",  64'(wraddrs), 64'h5);
    check("occ_opAB", oprndA, 64'h1111_0000_0000_0000);
    tick();
    rel = 1'b1; rel_addrs = 4'd5;
    #4; check("occ_blkC",   64'(gnt), 64'h0);
    check("occ_slotsC", 64'(slot_valid), 64'h0020);
    tick();
    rel = 1'b0;
    #4; check("occ_gntD", 64'(gnt), 64'h1);
    tick();
    req_addrs = 16'h0007;
    #4; check("se_gnt7", 64'(gnt), 64'h1);
    tick();
    req = 4'b0000; rel = 1'b1; rel_addrs = 4'd7;
    tick();
    rel_addrs = 4'd2;
    #4; check("se_setwins", 64'(slot_valid), 64'h00A0);
    tick();
    rel = 1'b0;
    #4; check("noop_rel", 64'(slot_valid), 64'h00A0);
    check("occ_cnt", 64'(issued_cnt), 64'h3);
    pulse_reset();
    tick();

    // Operator stall
    op_ready = 1'b0; req = 4'b0010; req_addrs = 16'h0090;
    #4; check("stall_gnt1", 64'(gnt), 64'h0);
    tick();
    #4; check("stall_gnt2", 64'(gnt), 64'h0);
    check("stall_wren", 64'(wren), 64'h0);
    tick();
    op_ready = 1'b1;
    #4; check("stall_gnt3", 64'(gnt), 64'h2);
    tick();
    req = 4'b0000;
    #4;
    pulse_reset();
    tick();

    // Two requesters on one slot
    req = 4'b0011; req_addrs = 16'h0044;
    #4; check("haz_gnt1", 64'(gnt), 64'h1);
    tick();
    req = 4'b0010;
    #4; check("haz_gnt2", 64'(gnt), 64'h0);
    tick();
    #4; check("haz_gnt3",  64'(gnt), 64'h0);
    check("haz_slots", 64'(slot_valid), 64'h0010);
    req = 4'b0000;
    pulse_reset();
    tick();

    // Counter wrap: one issue per cycle on rotating slots, release two behind
    for (int k = 0; k <= 65538; k++) begin
      req       = ((k <= 65534) || (k == 65536)) ? 4'b0001 : 4'b0000;
      req_addrs = {12'h000, 4'(k)};
      rel       = (k >= 2);
      rel_addrs = 4'(k - 2);
      #4;
      if (k == 1000) begin
        check("wrap_gnt1000", 64'(gnt), 64'h1);
        check("wrap_cnt1000", 64'(issued_cnt), 64'd999);
      end
      if (k == 65536) begin
        check("wrap_gnt_last", 64'(gnt), 64'h1);
        check("wrap_cnt_ffff", 64'(issued_cnt), 64'hFFFF);
      end
      if (k == 65537) check("wrap_cnt_hold", 64'(issued_cnt), 64'hFFFF);
      if (k == 65538) check("wrap_cnt_zero", 64'(issued_cnt), 64'h0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
